// File: rtl/mdc_pkg.sv
// Shared service codes, sequencer state encoding and default phase timings
// for the maquina_de_cafe dispenser.
package mdc_pkg;

    localparam logic [2:0] OUT_SERVIR_CAFE = 3'b101;
    localparam logic [2:0] OUT_SERVIR_TE   = 3'b110;
    localparam logic [2:0] OUT_DEVOLVER    = 3'b001;

    localparam int unsigned DEF_CW     = 16;
    localparam int unsigned DEF_T_HEAT = 8;
    localparam int unsigned DEF_T_CAFE = 12;
    localparam int unsigned DEF_T_TE   = 10;
    localparam int unsigned DEF_T_RET  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAT,
        ST_POUR,
        ST_RETURN,
        ST_DONE
    } disp_state_t;

endpackage

// File: rtl/mdc_timer.sv
// Loadable down-counter for phase timing; holds at zero instead of wrapping.
module mdc_timer #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] val,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mdc_dispensador.sv
// Actuator sequencer: turns a service code into timed heater/pump/valve/coin
// activity and reports completion with a one-cycle done (err on abort).
module mdc_dispensador
    import mdc_pkg::*;
#(
    parameter int unsigned CW     = DEF_CW,
    parameter int unsigned T_HEAT = DEF_T_HEAT,
    parameter int unsigned T_CAFE = DEF_T_CAFE,
    parameter int unsigned T_TE   = DEF_T_TE,
    parameter int unsigned T_RET  = DEF_T_RET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ha,
    output logic       heater,
    output logic       pump,
    output logic       valve_cafe,
    output logic       valve_te,
    output logic       coin_return,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CW-1:0] LD_HEAT = CW'(T_HEAT - 1);
    localparam logic [CW-1:0] LD_CAFE = CW'(T_CAFE - 1);
    localparam logic [CW-1:0] LD_TE   = CW'(T_TE - 1);
    localparam logic [CW-1:0] LD_RET  = CW'(T_RET - 1);

    disp_state_t   state, state_n;
    logic [2:0]    cmd_q;
    logic          err_q;
    logic          accept;
    logic          abort;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    mdc_timer #(.CW(CW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .val  (tmr_val),
        .zero (tmr_zero)
    );

    assign accept = cmd_valid && (state == ST_IDLE);
    assign abort  = ((state == ST_HEAT) || (state == ST_POUR)) && !ha;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cmd_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cmd_q <= cmd;
                err_q <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        OUT_SERVIR_CAFE, OUT_SERVIR_TE: begin
                            state_n  = ST_HEAT;
                            tmr_load = 1'b1;
                            tmr_val  = LD_HEAT;
                        end
                        OUT_DEVOLVER: begin
                            state_n  = ST_RETURN;
                            tmr_load = 1'b1;
                            tmr_val  = LD_RET;
                        end
                        default: state_n = ST_DONE;
                    endcase
                end
            end
            ST_HEAT: begin
                if (!ha) begin
                    state_n = ST_DONE;
                end else if (tmr_zero) begin
                    state_n  = ST_POUR;
                    tmr_load = 1'b1;
                    tmr_val  = (cmd_q == OUT_SERVIR_CAFE) ? LD_CAFE : LD_TE;
                end
            end
            ST_POUR: begin
                if (!ha || tmr_zero)
                    state_n = ST_DONE;
            end
            ST_RETURN: begin
                if (tmr_zero)
                    state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Moore decode of the registered state, so every output is glitch-free
    always_comb begin
        heater      = (state == ST_HEAT) || (state == ST_POUR);
        pump        = (state == ST_POUR);
        valve_cafe  = (state == ST_POUR) && (cmd_q == OUT_SERVIR_CAFE);
        valve_te    = (state == ST_POUR) && (cmd_q == OUT_SERVIR_TE);
        coin_return = (state == ST_RETURN);
        busy        = (state != ST_IDLE);
        cmd_ready   = (state == ST_IDLE);
        done        = (state == ST_DONE);
        err         = (state == ST_DONE) && err_q;
    end

endmodule

// File: tb/tb_mdc_dispensador.sv
// Directed bench for mdc_dispensador: expected per-command activity goes into a
// scoreboard when a command is issued and is checked when done appears.
module tb_mdc_dispensador;

    localparam int unsigned TH = 8;
    localparam int unsigned TC = 12;
    localparam int unsigned TT = 10;
    localparam int unsigned TR = 2;

    typedef struct {
        int unsigned heat;
        int unsigned pump;
        int unsigned vc;
        int unsigned vt;
        int unsigned coin;
        int unsigned lat;
        logic        err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ha;
    logic       heater, pump, valve_cafe, valve_te, coin_return;
    logic       busy, done, err;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    exp_t        sb[$];

    mdc_dispensador #(
        .CW(16), .T_HEAT(TH), .T_CAFE(TC), .T_TE(TT), .T_RET(TR)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .ha(ha), .heater(heater), .pump(pump), .valve_cafe(valve_cafe), .valve_te(valve_te),
        .coin_return(coin_return), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [2:0] code, input int unsigned abort_at);
        exp_t m;
        int unsigned plen;
        m.heat = 0; m.pump = 0; m.vc = 0; m.vt = 0; m.coin = 0; m.lat = 1; m.err = 1'b0;
        case (code)
            3'b101, 3'b110: begin
                plen   = (abort_at != 0) ? abort_at : ((code == 3'b101) ? TC : TT);
                m.heat = TH + plen;
                m.pump = plen;
                if (code == 3'b101) m.vc = plen; else m.vt = plen;
                m.lat  = TH + plen + 1;
                m.err  = (abort_at != 0);
            end
            3'b001: begin
                m.coin = TR;
                m.lat  = TR + 1;
            end
            default: m.lat = 1;
        endcase
        return m;
    endfunction

    task automatic run_cmd(input logic [2:0] code, input int unsigned abort_at);
        exp_t e, got;
        logic seen;
        got.heat = 0; got.pump = 0; got.vc = 0; got.vt = 0; got.coin = 0; got.lat = 0;
        got.err = 1'b0;
        seen = 1'b0;
        sb.push_back(model(code, abort_at));
        @(negedge clk);
        chk("ready_before", {31'd0, cmd_ready}, 1);
        cmd       = code;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int unsigned cyc = 1; cyc <= 64 && !seen; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (heater)      got.heat++;
            if (pump)        got.pump++;
            if (valve_cafe)  got.vc++;
            if (valve_te)    got.vt++;
            if (coin_return) got.coin++;
            chk("valve_excl", {31'd0, valve_cafe & valve_te}, 0);
            chk("pump_one_valve", {31'd0, pump & ~(valve_cafe ^ valve_te)}, 0);
            chk("err_only_done", {31'd0, err & ~done}, 0);
            chk("ready_low", {30'd0, cmd_ready, busy}, 2'b01);
            if (abort_at != 0 && pump && got.pump == abort_at) ha = 1'b0;
            if (done) begin
                seen    = 1'b1;
                got.lat = cyc;
                got.err = err;
            end
        end
        ha = 1'b1;
        if (!seen) chk("done_timeout", 0, 1);
        e = sb.pop_front();
        chk("heater_cycles", got.heat, e.heat);
        chk("pump_cycles",   got.pump, e.pump);
        chk("vcafe_cycles",  got.vc,   e.vc);
        chk("vte_cycles",    got.vt,   e.vt);
        chk("coin_cycles",   got.coin, e.coin);
        chk("done_latency",  got.lat,  e.lat);
        chk("done_err",      {31'd0, got.err}, {31'd0, e.err});
        @(negedge clk);
        chk("post_idle", {26'd0, done, err, busy, cmd_ready, heater, pump}, 6'b000100);
    endtask

    initial begin
        int unsigned pours;
        rst       = 1'b1;
        cmd       = 3'b000;
        cmd_valid = 1'b0;
        ha        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            {23'd0, heater, pump, valve_cafe, valve_te, coin_return, busy, done, err, cmd_ready},
            9'b000000001);

        run_cmd(3'b110, 0);
        run_cmd(3'b101, 0);
        run_cmd(3'b001, 0);
        run_cmd(3'b101, 4);

        // Reset in the middle of a tea pour
        @(negedge clk);
        cmd       = 3'b110;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        pours = 0;
        for (int unsigned i = 0; i < 40 && pours < 3; i++) begin
            if (pump) pours++;
            if (pours < 3) @(negedge clk);
        end
        chk("pour_reached", pours, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs",
            {23'd0, heater, pump, valve_cafe, valve_te, coin_return, busy, done, err, cmd_ready},
            9'b000000001);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_no_done", {30'd0, done, busy}, 2'b00);

        run_cmd(3'b011, 0);
        run_cmd(3'b000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
